uart_tx_arbiter: RTL and testbench

- Shares one `uart_tx` serializer among `NUM_REQ` byte-stream requesters (e.g. AXI UART slave, debug logger, boot monitor).
- Arbitration is round-robin with packet locking: a granted requester keeps the transmitter until its `last` byte is sent or a burst cap is reached.
- Sits between the requesters and `uart_tx`: it drives `data_in`/`tx_start` and sequences on `tx_done`.

---
 rtl/uart_pkg.sv | 12 +
 rtl/rr_picker.sv | 31 +++
 rtl/uart_tx_arbiter_chk.sv | 21 ++
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and byte width.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority selector: returns the first set request at or above ptr,
// wrapping around; the pointer register itself lives in the arbiter FSM.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  int unsigned idx_s;

  // Scan requesters in rotated order and keep the first hit
  always_comb begin
    gnt_id = {ID_W{1'b0}};
    any    = 1'b0;
    idx_s  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = (int'(ptr) + k) % NUM_REQ;
      if (req[idx_s] && !any) begin
        any    = 1'b1;
        gnt_id = ID_W'(idx_s);
      end else begin
        gnt_id = gnt_id;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter_chk.sv
// Handshake invariants of the arbiter, kept apart from the datapath.
module uart_tx_arbiter_chk #(
  parameter int NUM_REQ = 4
) (
  input logic               clk,
  input logic               reset,
  input logic [NUM_REQ-1:0] req_ready,
  input logic               busy,
  input logic               tx_start
);

  a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(req_ready));

  a_ready_busy: assert property (@(posedge clk) disable iff (reset)
    (req_ready != {NUM_REQ{1'b0}}) |-> busy);

  a_start_busy: assert property (@(posedge clk) disable iff (reset)
    tx_start |-> busy);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet locking that shares one uart_tx among
// NUM_REQ byte-stream requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]         tx_data,
  output logic                           tx_start,
  input  logic                           tx_done,
  output logic [ID_W-1:0]                grant_id,
  output logic                           busy
);

  localparam int                CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

  arb_state_t               state_r;
  arb_state_t               state_nxt_s;
  logic [ID_W-1:0]          grant_id_r;
  logic [ID_W-1:0]          rr_ptr_r;
  logic [ID_W-1:0]          pick_id_s;
  logic                     any_s;
  logic [CNT_W-1:0]         burst_cnt_r;
  logic [CNT_W-1:0]         burst_inc_s;
  logic                     lock_r;
  logic [UART_BYTE_W-1:0]   tx_data_r;
  logic                     tx_start_r;
  logic                     cur_valid_s;
  logic                     cur_last_s;
  logic [UART_BYTE_W-1:0]   cur_data_s;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
    if (id == LAST_ID) begin
      return {ID_W{1'b0}};
    end else begin
      return id + ID_W'(1);
    end
  endfunction

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req    (req_valid),
    .ptr    (rr_ptr_r),
    .gnt_id (pick_id_s),
    .any    (any_s)
  );

  assign cur_valid_s = req_valid[grant_id_r];
  assign cur_last_s  = req_last[grant_id_r];
  assign cur_data_s  = req_data[UART_BYTE_W*grant_id_r +: UART_BYTE_W];
  assign burst_inc_s = burst_cnt_r + CNT_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a granted requester dropping valid releases the lock
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_s) state_nxt_s = ST_SEND;
        else       state_nxt_s = ST_IDLE;
      end
      ST_SEND: begin
        if (cur_valid_s) state_nxt_s = ST_WAIT;
        else             state_nxt_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (tx_done) state_nxt_s = lock_r ? ST_SEND : ST_IDLE;
        else         state_nxt_s = ST_WAIT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode: only the granted requester sees ready, and only in SEND
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (state_r == ST_SEND) begin
      req_ready[grant_id_r] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
    busy = (state_r != ST_IDLE);
  end

  // Grant, burst accounting and the registered byte/start pulse to uart_tx
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id_r  <= {ID_W{1'b0}};
      rr_ptr_r    <= {ID_W{1'b0}};
      burst_cnt_r <= {CNT_W{1'b0}};
      lock_r      <= 1'b0;
      tx_data_r   <= {UART_BYTE_W{1'b0}};
      tx_start_r  <= 1'b0;
    end else begin
      tx_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            grant_id_r  <= pick_id_s;
            rr_ptr_r    <= wrap_inc(pick_id_s);
            burst_cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_SEND: begin
          if (cur_valid_s) begin
            tx_data_r   <= cur_data_s;
            tx_start_r  <= 1'b1;
            burst_cnt_r <= burst_inc_s;
            lock_r      <= !cur_last_s && (burst_inc_s < BURST_MAX);
          end else begin
            lock_r      <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign tx_data  = tx_data_r;
  assign tx_start = tx_start_r;
  assign grant_id = grant_id_r;

  uart_tx_arbiter_chk #(
    .NUM_REQ (NUM_REQ)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .req_ready (req_ready),
    .busy      (busy),
    .tx_start  (tx_start)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: requester queues feed the arbiter, a packet-level
// round-robin model predicts the byte stream, a monitor checks each tx_start.
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int MB  = 4;
  localparam int IDW = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NR-1:0]       req_valid;
  logic [8*NR-1:0]     req_data;
  logic [NR-1:0]       req_last;
  logic [NR-1:0]       req_ready;
  logic [7:0]          tx_data;
  logic                tx_start;
  logic                tx_done;
  logic [IDW-1:0]      grant_id;
  logic                busy;

  int         vectors = 0;
  int         miscompares = 0;
  bit [8:0]   rq [NR][$];     // {last, data} per requester
  logic [9:0] exp_q [$];      // {grant_id, data}
  bit [NR-1:0] hold;
  bit         rand_delay;
  bit         spur_done;
  int         ucnt;
  int         mptr;

  uart_tx_arbiter #(
    .NUM_REQ   (NR),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_done   (tx_done),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Packet-level reference: rotate from mptr, serve until last or burst cap.
  task automatic model_push();
    bit [8:0] mq [NR][$];
    bit [8:0] b;
    int g, cnt, idx;
    bit found;
    for (int i = 0; i < NR; i++) mq[i] = rq[i];
    while (1) begin
      found = 1'b0;
      g = 0;
      for (int k = 0; k < NR; k++) begin
        idx = (mptr + k) % NR;
        if (!found && mq[idx].size() > 0) begin
          found = 1'b1;
          g = idx;
        end
      end
      if (!found) break;
      mptr = (g + 1) % NR;
      cnt = 0;
      while (mq[g].size() > 0 && cnt < MB) begin
        b = mq[g].pop_front();
        exp_q.push_back({IDW'(g), b[7:0]});
        cnt++;
        if (b[8]) break;
      end
    end
  endtask

  // Requesters and a uart_tx stand-in
  initial begin
    bit [NR-1:0] acc;
    bit v;
    req_valid = '0; req_data = '0; req_last = '0;
    tx_done = 1'b0; ucnt = 0; acc = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        for (int i = 0; i < NR; i++) rq[i].delete();
        acc = '0; ucnt = 0; tx_done = 1'b0;
      end else begin
        for (int i = 0; i < NR; i++)
          if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        tx_done = 1'b0;
        if (spur_done) begin
          tx_done = 1'b1;
          spur_done = 1'b0;
        end else if (ucnt > 0) begin
          ucnt--;
          if (ucnt == 0) tx_done = 1'b1;
        end
        if (tx_start) ucnt = rand_delay ? int'($urandom_range(12, 1)) : 10;
      end
      for (int i = 0; i < NR; i++) begin
        v = !hold[i] && (rq[i].size() > 0);
        req_valid[i] = v;
        req_data[8*i +: 8] = v ? rq[i][0][7:0] : 8'h00;
        req_last[i] = v ? rq[i][0][8] : 1'b0;
      end
      acc = req_valid & req_ready;
    end
  end

  // Monitor: pops the scoreboard on every start pulse
  initial begin
    logic [9:0] e;
    logic [7:0] last_data;
    last_data = 8'h00;
    forever begin
      @(posedge clk); #2;
      if (!reset) begin
        check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        if (req_ready != '0) check("ready_while_busy", 32'(busy), 32'd1);
        if (tx_start) begin
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_start: got data 0x%0h id %0d, expected no start", tx_data, grant_id);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", 32'(tx_data), 32'(e[7:0]));
            check("grant_id", 32'(grant_id), 32'(e[9:8]));
          end
          last_data = tx_data;
        end
        if (tx_done && busy) check("data_hold", 32'(tx_data), 32'(last_data));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #3 reset = 1'b0;
    mptr = 0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    bit done = 1'b0;
    while (n < budget && !done) begin
      done = (exp_q.size() == 0) && (ucnt == 0) && !tx_done;
      for (int i = 0; i < NR; i++) if (rq[i].size() > 0) done = 1'b0;
      if (!done) begin
        @(posedge clk); #3;
        n++;
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: got %0d pending bytes, expected 0", name, exp_q.size());
    end
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int nb, len, got;
    bit any;
    reset = 1'b1; hold = '0; rand_delay = 1'b0; spur_done = 1'b0; mptr = 0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;

    // single requester, three-byte packet
    rq[1].push_back(9'h041); rq[1].push_back(9'h042); rq[1].push_back(9'h143);
    model_push();
    wait_idle(300, "single");
    check("single_grant_kept", 32'(grant_id), 32'd1);

    // round-robin order 0,2,3,0
    do_reset();
    rq[0].push_back(9'h101); rq[0].push_back(9'h102);
    rq[2].push_back(9'h1A0); rq[3].push_back(9'h1B0);
    model_push();
    wait_idle(300, "rr");

    // burst cap splits req1's six bytes around req2
    do_reset();
    for (int b = 0; b < 6; b++) rq[1].push_back({(b == 5), 8'(8'h30 + b)});
    rq[2].push_back(9'h1C0);
    model_push();
    wait_idle(400, "burst");

    // lock loss: req0 stops mid-packet, req1 takes over
    do_reset();
    rq[0].push_back(9'h010); rq[0].push_back(9'h111);
    rq[1].push_back(9'h020); rq[1].push_back(9'h121);
    exp_q.push_back({2'd0, 8'h10}); exp_q.push_back({2'd1, 8'h20});
    exp_q.push_back({2'd1, 8'h21}); exp_q.push_back({2'd0, 8'h11});
    got = 0;
    while (rq[0].size() != 1 && got < 50) begin @(posedge clk); #3; got++; end
    check("lockloss_first_taken", 32'(rq[0].size()), 32'd1);
    hold[0] = 1'b1;
    repeat (40) @(posedge clk);
    #3 hold[0] = 1'b0;
    wait_idle(400, "lockloss");

    // randomized rounds
    do_reset();
    rand_delay = 1'b1;
    for (int r = 0; r < 12; r++) begin
      any = 1'b0;
      for (int i = 0; i < NR; i++) begin
        nb = $urandom_range(2, 0);
        for (int p = 0; p < nb; p++) begin
          len = $urandom_range(7, 1);
          for (int b = 0; b < len; b++) rq[i].push_back({(b == len - 1), 8'($urandom_range(255, 0))});
          any = 1'b1;
        end
      end
      if (!any) rq[r % NR].push_back({1'b1, 8'($urandom_range(255, 0))});
      model_push();
      wait_idle(3000, "random");
    end
    rand_delay = 1'b0;

    // reset three cycles into WAIT, then a spurious tx_done
    do_reset();
    rq[2].push_back(9'h055); rq[2].push_back(9'h156);
    exp_q.push_back({2'd2, 8'h55});
    got = 0;
    while (!tx_start && got < 20) begin @(posedge clk); #3; got++; end
    check("midwait_start_seen", 32'(tx_start), 32'd1);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #3;
    check("midwait_busy", 32'(busy), 32'd0);
    check("midwait_ready", 32'(req_ready), 32'd0);
    check("midwait_tx_start", 32'(tx_start), 32'd0);
    check("midwait_grant", 32'(grant_id), 32'd0);
    check("midwait_tx_data", 32'(tx_data), 32'd0);
    reset = 1'b0;
    spur_done = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    check("spurious_done_busy", 32'(busy), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
